// File: rtl/mux_4_1_if.sv
// mux_4_1 data bundle: four inputs, select, and comb/registered outputs.
// master drives in1..in4 and s; slave returns y, y_q and s_q.
interface mux_4_1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] in4;
  logic [1:0]       s;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       s_q;

  modport master (
    output in1, in2, in3, in4, s,
    input  y, y_q, s_q
  );

  modport slave (
    input  in1, in2, in3, in4, s,
    output y, y_q, s_q
  );
endinterface

// File: rtl/mux_4_1.sv
// 4:1 mux leaf cell: comb y = in[s], plus y_q/s_q registered copies.
// Ports: clk, rst (sync, active-high, regs only), bus (slave modport).
module mux_4_1 #(
  parameter int WIDTH = 1
) (
  input logic      clk,
  input logic      rst,
  mux_4_1_if.slave bus
);

  always_comb begin
    bus.y = bus.in1;
    case (bus.s)
      2'b00: bus.y = bus.in1;
      2'b01: bus.y = bus.in2;
      2'b10: bus.y = bus.in3;
      2'b11: bus.y = bus.in4;
      // Only reachable on X/Z select in simulation; propagate it.
      default: bus.y = $isunknown(bus.s) ?
                       {WIDTH{1'bx}} : bus.in1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.y_q <= {WIDTH{1'b0}};
      bus.s_q <= 2'b00;
    end else begin
      bus.y_q <= bus.y;
      bus.s_q <= bus.s;
    end
  end

endmodule

// File: tb/tb_mux_4_1.sv
// Bench for mux_4_1: WIDTH=1 and WIDTH=8 instances side by side.
// Comb y checked inline; y_q/s_q checked by a queue-driven monitor.
module tb_mux_4_1;

  typedef struct packed {
    logic [7:0] yq;
    logic [1:0] sq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  mux_4_1_if #(.WIDTH(1)) b1 ();
  mux_4_1_if #(.WIDTH(8)) b8 ();

  mux_4_1 #(.WIDTH(1)) u1 (
    .clk(clk),
    .rst(rst),
    .bus(b1)
  );

  mux_4_1 #(.WIDTH(8)) u8 (
    .clk(clk),
    .rst(rst),
    .bus(b8)
  );

  task automatic chk(input string name,
                     input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("w1 y_q", {7'd0, b1.y_q}, e.yq);
      chk("w1 s_q", {6'd0, b1.s_q}, {6'd0, e.sq});
    end
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk("w8 y_q", b8.y_q, e.yq);
      chk("w8 s_q", {6'd0, b8.s_q}, {6'd0, e.sq});
    end
  end

  // d1/d8 packed as {in4,in3,in2,in1}; e1/e8 are hand-computed y.
  task automatic step(input logic        r,
                      input logic [3:0]  d1,
                      input logic [1:0]  s1,
                      input logic        e1,
                      input logic [31:0] d8,
                      input logic [1:0]  s8,
                      input logic [7:0]  e8);
    exp_t x;
    @(negedge clk);
    #1;
    rst    = r;
    b1.in1 = d1[0];
    b1.in2 = d1[1];
    b1.in3 = d1[2];
    b1.in4 = d1[3];
    b1.s   = s1;
    b8.in1 = d8[7:0];
    b8.in2 = d8[15:8];
    b8.in3 = d8[23:16];
    b8.in4 = d8[31:24];
    b8.s   = s8;
    #1;
    chk("w1 y", {7'd0, b1.y}, {7'd0, e1});
    chk("w8 y", b8.y, e8);
    x.yq = r ? 8'h00 : {7'd0, e1};
    x.sq = r ? 2'b00 : s1;
    q1.push_back(x);
    x.yq = r ? 8'h00 : e8;
    x.sq = r ? 2'b00 : s8;
    q8.push_back(x);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Reset held two edges; comb y is live meanwhile.
    step(1'b1, 4'b0100, 2'b00, 1'b0,
         32'h44332211, 2'b00, 8'h11);
    step(1'b1, 4'b0101, 2'b00, 1'b1,
         32'h44332211, 2'b00, 8'h11);
    step(1'b0, 4'b0100, 2'b11, 1'b0,
         32'h44332211, 2'b01, 8'h22);
    step(1'b0, 4'b1100, 2'b11, 1'b1,
         32'h44332211, 2'b10, 8'h33);
    // in3 toggles while s=11: y must hold.
    step(1'b0, 4'b1000, 2'b11, 1'b1,
         32'h44332211, 2'b11, 8'h44);
    step(1'b0, 4'b0100, 2'b10, 1'b1,
         32'h44332211, 2'b00, 8'h11);
    // Mid-stream reset: regs clear, y unaffected.
    step(1'b1, 4'b0100, 2'b10, 1'b1,
         32'h44332211, 2'b01, 8'h22);
    step(1'b0, 4'b0100, 2'b10, 1'b1,
         32'h44332211, 2'b10, 8'h33);
    step(1'b0, 4'b0001, 2'b01, 1'b0,
         32'hA5C33C5A, 2'b11, 8'hA5);
    step(1'b0, 4'b0010, 2'b01, 1'b1,
         32'hA5C33C5A, 2'b00, 8'h5A);
    step(1'b0, 4'b1000, 2'b11, 1'b1,
         32'hA5C33C5A, 2'b10, 8'hC3);
    step(1'b0, 4'b0111, 2'b11, 1'b0,
         32'hA5C33C5A, 2'b01, 8'h3C);
    repeat (3) @(negedge clk);
    #2;
    chk("w1 queue drained", 8'(q1.size()), 8'd0);
    chk("w8 queue drained", 8'(q8.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
